// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational instruction
// memory and loads the IF/ID register. Handles stall, branch redirect and HALT.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        if_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t      state, state_d;
    logic [15:0] pc, pc_d;
    logic [15:0] instr_d, ifpc_d, cnt_d;
    logic        valid_d;
    logic [15:0] target;

    // Instructions are halfword aligned, so bit 0 of any address is forced low.
    assign target      = redirect_pc & 16'hFFFE;
    assign imem_addr   = pc & 16'hFFFE;
    assign if_pc_plus2 = if_pc + 16'd2;
    assign halted      = (state == S_HALT);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_RUN;
        else          state <= state_d;
    end

    // Next state and next datapath values; redirect beats stall beats fetch
    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = if_instr;
        ifpc_d  = if_pc;
        valid_d = if_valid;
        cnt_d   = fetch_count;
        case (state)
            S_RUN: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    instr_d = 16'h0000;
                end else if (!stall) begin
                    instr_d = imem_data;
                    ifpc_d  = pc;
                    valid_d = 1'b1;
                    cnt_d   = fetch_count + 16'd1;
                    // PC stays parked on the halt word so a reset-free redirect is the only way on
                    if (imem_data == HALT_WORD) state_d = S_HALT;
                    else                        pc_d    = pc + 16'd2;
                end
            end
            S_HALT: begin
                // The halt word was shown to decode for one cycle; bubbles from now on.
                valid_d = 1'b0;
                if (redirect) begin
                    // Halt was fetched down the wrong path of a taken branch
                    pc_d    = target;
                    instr_d = 16'h0000;
                    state_d = S_RUN;
                end
            end
        endcase
    end

    // PC and IF/ID pipeline register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            if_instr    <= 16'h0000;
            if_pc       <= 16'h0000;
            if_valid    <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            pc          <= pc_d;
            if_instr    <= instr_d;
            if_pc       <= ifpc_d;
            if_valid    <= valid_d;
            fetch_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then random
// stall/redirect/halt traffic against a behavioural fetch model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] imem_addr, imem_data;
    logic        stall, redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_instr, if_pc, if_pc_plus2, fetch_count;
    logic        if_valid, halted;

    logic [15:0] mem [0:32767];
    int n_assert = 0;
    int n_fail   = 0;

    // behavioural model state
    logic [15:0] m_pc, m_instr, m_ifpc, m_cnt;
    logic        m_valid, m_halted;

    instr_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus2(if_pc_plus2),
        .if_valid(if_valid), .halted(halted), .fetch_count(fetch_count)
    );

    assign imem_data = mem[imem_addr[15:1]];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_ifpc = 16'h0000;
        m_cnt = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // One clock edge worth of fetch behaviour, written from the rules directly.
    task automatic model_edge(input logic st, input logic rd, input logic [15:0] rp);
        logic [15:0] word;
        word = mem[m_pc[15:1]];
        if (rd) begin
            m_pc = {rp[15:1], 1'b0};
            m_valid = 1'b0;
            m_instr = 16'h0000;
            m_halted = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (!st) begin
            m_instr = word;
            m_ifpc = m_pc;
            m_valid = 1'b1;
            m_cnt = m_cnt + 16'd1;
            if (word == 16'hFFFF) m_halted = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", if_pc, m_ifpc);
        chk("if_pc_plus2", if_pc_plus2, m_ifpc + 16'd2);
        chk("if_valid", {15'd0, if_valid}, {15'd0, m_valid});
        chk("halted", {15'd0, halted}, {15'd0, m_halted});
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic step(input logic st, input logic rd, input logic [15:0] rp);
        stall = st; redirect = rd; redirect_pc = rp;
        @(posedge clk);
        model_edge(st, rd, rp);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_plus2", if_pc_plus2, 16'h0002);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] saved_cnt;
        int guard;

        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        mem[16'h0000 >> 1] = 16'h0120;
        mem[16'h0002 >> 1] = 16'h0121;
        mem[16'h0004 >> 1] = 16'h23FF;
        mem[16'h0036 >> 1] = 16'hFFFF;
        mem[16'hFFFE >> 1] = 16'h1234;

        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        model_reset();
        #2;
        check_all();
        chk("rst_plus2", if_pc_plus2, 16'h0002);
        reset_n = 1'b1;

        // straight-line fetch
        step(0, 0, 16'h0); chk("e1_instr", if_instr, 16'h0120);
        step(0, 0, 16'h0); chk("e2_instr", if_instr, 16'h0121);

        // two stall cycles hold everything
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 16'h0);
            chk("stall_instr", if_instr, 16'h0121);
            chk("stall_addr", imem_addr, 16'h0004);
            chk("stall_cnt", fetch_count, 16'd2);
        end
        step(0, 0, 16'h0);
        chk("e3_instr", if_instr, 16'h23FF);
        chk("e3_pc", if_pc, 16'h0004);
        chk("e3_cnt", fetch_count, 16'd3);

        // redirect with odd target and stall asserted: redirect wins
        step(1, 1, 16'h0021);
        chk("redir_addr", imem_addr, 16'h0020);
        chk("redir_valid", {15'd0, if_valid}, 16'd0);
        chk("redir_instr", if_instr, 16'h0000);
        step(0, 0, 16'h0);
        chk("redir_pc", if_pc, 16'h0020);
        chk("redir_word", if_instr, mem[16'h0020 >> 1]);

        // run up to the halt word at 0036
        guard = 0;
        while (!m_halted && guard < 40) begin step(0, 0, 16'h0); guard++; end
        chk("halt_reached", {15'd0, halted}, 16'd1);
        chk("halt_instr", if_instr, 16'hFFFF);
        chk("halt_pc", if_pc, 16'h0036);
        chk("halt_valid", {15'd0, if_valid}, 16'd1);
        saved_cnt = fetch_count;
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 0, 16'h0);
            chk("hold_valid", {15'd0, if_valid}, 16'd0);
            chk("hold_addr", imem_addr, 16'h0036);
            chk("hold_cnt", fetch_count, saved_cnt);
        end

        // redirect out of HALT
        step(0, 1, 16'h0024);
        chk("unhalt", {15'd0, halted}, 16'd0);
        step(0, 0, 16'h0);
        chk("unhalt_word", if_instr, mem[16'h0024 >> 1]);
        guard = 0;
        while (m_pc != 16'h0036 && guard < 40) begin step(0, 0, 16'h0); guard++; end
        chk("at_halt_addr", imem_addr, 16'h0036);
        // redirect concurrent with FFFF on imem_data
        step(0, 1, 16'h0040);
        chk("no_halt", {15'd0, halted}, 16'd0);
        step(0, 0, 16'h0);
        chk("no_halt2", {15'd0, halted}, 16'd0);

        // PC wrap at FFFE
        step(0, 1, 16'hFFFF);
        chk("wrap_addr0", imem_addr, 16'hFFFE);
        step(0, 0, 16'h0);
        chk("wrap_pc", if_pc, 16'hFFFE);
        chk("wrap_plus2", if_pc_plus2, 16'h0000);
        chk("wrap_addr", imem_addr, 16'h0000);

        async_reset();

        // random traffic with occasional halt words and resets
        for (int i = 0; i < 32768; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
                 16'($urandom_range(0, 16'hFFFF)));
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the 16-bit MIPS-style CPU. Owns the program counter, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Handles pipeline stalls, branch redirects from the execute stage, and the HALT word (16'hFFFF). Sits between the instruction memory and the decode stage.

## Interface

- RESET_PC, 16'h0000, PC value loaded on reset
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetch

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  16  instruction memory address; equals PC, bit 0 always 0
- imem_data  in  16  instruction word returned combinationally for imem_addr
- stall  in  1  hazard unit hold request; freezes PC and IF/ID register
- redirect  in  1  taken branch from execute stage
- redirect_pc  in  16  branch target; bit 0 ignored
- if_instr  out  16  IF/ID instruction register
- if_pc  out  16  address of if_instr
- if_pc_plus2  out  16  if_pc + 2, mod 2^16
- if_valid  out  1  if_instr holds a real instruction; 0 = bubble
- halted  out  1  fetch stopped on HALT_WORD
- fetch_count  out  16  number of valid instructions captured, wraps at 16'hFFFF

## Operation

- Two states: RUN, HALT. Reset enters RUN.
- imem_addr = {pc[15:1], 1'b0} combinationally in both states.
- Priority per rising edge: redirect > stall > normal fetch.
- RUN, redirect=1: pc <= {redirect_pc[15:1],1'b0}; if_valid <= 0; if_instr <= 16'h0000; if_pc unchanged; fetch_count unchanged; stay RUN. Applies even if stall=1.
- RUN, stall=1, redirect=0: pc, if_instr, if_pc, if_valid, fetch_count hold.
- RUN, normal: if_instr <= imem_data; if_pc <= pc; if_valid <= 1; fetch_count <= fetch_count + 1.
  - imem_data != HALT_WORD: pc <= pc + 2 (16'hFFFE wraps to 16'h0000).
  - imem_data == HALT_WORD: pc holds (points at the halt word); next state HALT; halted <= 1.
- HALT, redirect=0: pc holds; if_valid <= 0 (halt word presented to decode exactly one cycle); if_instr holds HALT_WORD; halted stays 1; stall has no effect.
- HALT, redirect=1: halt was fetched speculatively behind a taken branch; pc <= target; if_valid <= 0; if_instr <= 16'h0000; halted <= 0; state RUN.
- if_pc_plus2 is combinational from if_pc.
- No other exit from HALT except reset.

## Timing

- Reset (async assert, any time, including mid-stall or in HALT): pc = RESET_PC, imem_addr = RESET_PC, if_instr = 16'h0000, if_pc = 16'h0000, if_pc_plus2 = 16'h0002, if_valid = 0, halted = 0, fetch_count = 0, state RUN. Deassertion is synchronized externally.
- Fetch latency: word at imem_addr appears on if_instr at the next rising edge; one instruction per cycle without stall.
- Redirect: target's instruction on if_instr two edges after redirect is sampled (one bubble cycle with if_valid = 0).
- Stall: every output holds for each stalled cycle; imem_addr stable.
- Halt: halted rises at the same edge the halt word is captured; if_valid falls one edge later.
- Simultaneous redirect and halt word on imem_data: redirect wins; halt word discarded, halted stays 0.

## Test plan

- Reset release, program 0120@0000, 0121@0002, 23FF@0004, no stall -> if_instr 0120/0121/23FF on edges 1/2/3, if_pc 0000/0002/0004, if_valid 1, fetch_count 3.
- stall high for 2 cycles after if_instr=0121 -> if_instr, if_pc, imem_addr=0004, fetch_count hold 2 cycles, then 23FF captured.
- redirect=1, redirect_pc=16'h0021 while pc=0006 -> next edge imem_addr=0020, if_valid=0, if_instr=0000; following edge if_instr=mem[0020], if_pc=0020.
- HALT word FFFF@0036 -> if_instr=FFFF, if_pc=0036, if_valid=1, halted=1; next edge if_valid=0; pc stays 0036 for 10 further cycles, fetch_count unchanged, stall ignored.
- In HALT, redirect to 0024 -> halted=0, bubble, then if_instr=mem[0024]; separately redirect concurrent with FFFF on imem_data -> halted never asserts.
- pc=FFFE, non-halt word, no stall -> if_pc=FFFE, if_pc_plus2=0000, imem_addr wraps to 0000; async reset asserted mid-cycle -> all outputs at reset values immediately.
